// File: rtl/wb_arb_pkg.sv
// Shared types and default sizing for the Wishbone arbiter with watchdog.
`timescale 1ns / 1ps
package wb_arb_pkg;

    localparam int unsigned DEF_NM     = 3;
    localparam int unsigned DEF_GNTW   = 2;
    localparam int unsigned DEF_TMO_W  = 8;
    localparam int unsigned DEF_STAT_W = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StTmo  = 2'd2
    } state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority picker: the first requester after last_i wins, wrapping.
`timescale 1ns / 1ps
module wb_rr_pick #(
    parameter int unsigned NM   = 3,
    parameter int unsigned GNTW = 2
) (
    input  logic [NM-1:0]   req_i,
    input  logic [GNTW-1:0] last_i,
    output logic [GNTW-1:0] winner_o,
    output logic            any_o
);

    int unsigned idx;

    // Scan offsets 1..NM from last_i; last_i itself is visited last (lowest priority).
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= NM; i++) begin
            idx = (32'(last_i) + i) % NM;
            for (int unsigned j = 0; j < NM; j++) begin
                if (!any_o && (idx == j) && req_i[j]) begin
                    winner_o = GNTW'(j);
                    any_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_arb_tmo.sv
// Round-robin Wishbone bus arbiter with per-beat response watchdog and timeout stats.
`timescale 1ns / 1ps
module wb_arb_tmo
    import wb_arb_pkg::*;
#(
    parameter int unsigned NM     = DEF_NM,
    parameter int unsigned GNTW   = DEF_GNTW,
    parameter int unsigned TMO_W  = DEF_TMO_W,
    parameter int unsigned STAT_W = DEF_STAT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NM-1:0]     req_i,
    input  logic              stb_i,
    input  logic              ack_i,
    input  logic              err_i,
    input  logic              rty_i,
    input  logic [TMO_W-1:0]  tmo_limit_i,
    output logic [GNTW-1:0]   gnt_o,
    output logic              gnt_vld_o,
    output logic              tmo_err_o,
    output logic [STAT_W-1:0] tmo_cnt_o,
    output logic [GNTW-1:0]   tmo_mst_o
);

    state_e            state_q, state_d;
    logic [GNTW-1:0]   gnt_q, gnt_d;
    logic [GNTW-1:0]   ptr_q, ptr_d;
    logic [GNTW-1:0]   mst_q, mst_d;
    logic [TMO_W-1:0]  w_q, w_d;
    logic              pend_q, pend_d;
    logic [STAT_W-1:0] cnt_q, cnt_d;

    logic [GNTW-1:0]   pick_win;
    logic              pick_any;
    logic              owner_req;
    logic              resp;
    logic              wd_en;
    logic              waiting;
    logic              tmo_hit;
    logic              tmo_fire;

    // ptr_q only differs from gnt_q out of reset, where it makes master 0 highest priority.
    wb_rr_pick #(
        .NM   (NM),
        .GNTW (GNTW)
    ) u_pick (
        .req_i    (req_i),
        .last_i   (ptr_q),
        .winner_o (pick_win),
        .any_o    (pick_any)
    );

    assign owner_req = |(req_i & (NM'(1) << gnt_q));
    assign resp      = ack_i | err_i | rty_i;
    assign wd_en     = (tmo_limit_i != '0);
    assign waiting   = stb_i & ~resp;
    assign tmo_hit   = wd_en && waiting && (w_q == (tmo_limit_i - TMO_W'(1)));
    // A real response in the pending cycle wins over the synthesized error.
    assign tmo_fire  = (state_q == StTmo) && pend_q && !resp && wd_en;

    // Next-state logic for arbitration FSM, watchdog counter and statistics.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        mst_d   = mst_q;
        w_d     = w_q;
        pend_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                w_d = '0;
                if (pick_any) begin
                    gnt_d   = pick_win;
                    ptr_d   = pick_win;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (!owner_req) begin
                    w_d = '0;
                    if (pick_any) begin
                        gnt_d = pick_win;
                        ptr_d = pick_win;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (tmo_hit) begin
                    w_d     = '0;
                    pend_d  = 1'b1;
                    state_d = StTmo;
                end else if (wd_en && waiting) begin
                    w_d = (w_q == '1) ? w_q : w_q + TMO_W'(1);
                end else begin
                    w_d = '0;
                end
            end
            StTmo: begin
                w_d = '0;
                if (tmo_fire) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + STAT_W'(1);
                    mst_d = gnt_q;
                end
                // Grant is held until the stalled master withdraws its strobe.
                if (!stb_i) begin
                    if (owner_req) begin
                        state_d = StOwn;
                    end else if (pick_any) begin
                        gnt_d   = pick_win;
                        ptr_d   = pick_win;
                        state_d = StOwn;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= GNTW'(NM - 1);
            mst_q   <= '0;
            w_q     <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            mst_q   <= mst_d;
            w_q     <= w_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_vld_o = (state_q != StIdle);
    assign tmo_err_o = tmo_fire;
    assign tmo_cnt_o = cnt_q;
    assign tmo_mst_o = mst_q;

endmodule
